// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single-precision adder: ALIGN/ADD/NORM sequencing,
// denormals flushed to zero, truncating alignment, no inf/NaN inputs.
module fp_add_sequencer #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  localparam logic [7:0] STEP = 8'(SHIFT_STEP);

  state_t      state_q;
  logic [23:0] ma_q, mb_q;
  logic [7:0]  ea_q, eb_q;
  logic        sa_q, sb_q;
  logic [24:0] sum_q;
  logic [8:0]  exp_q;
  logic        sign_q;
  logic [31:0] result_q;
  logic        out_valid_q, busy_q;

  logic        a_lt;
  logic [7:0]  diff, step;
  logic        zero_case;
  logic [24:0] add_sum_d;
  logic        add_sign_d;
  logic [8:0]  exp_inc, exp_dec;

  always_comb begin
    a_lt      = ea_q < eb_q;
    diff      = a_lt ? (eb_q - ea_q) : (ea_q - eb_q);
    step      = (diff < STEP) ? diff : STEP;
    zero_case = (ea_q == 8'd0) || (eb_q == 8'd0) || (diff > 8'd24);
    exp_inc   = exp_q + 9'd1;
    exp_dec   = exp_q - 9'd1;
    add_sum_d  = 25'd0;
    add_sign_d = 1'b0;
    if (sa_q == sb_q) begin
      add_sum_d  = {1'b0, ma_q} + {1'b0, mb_q};
      add_sign_d = sa_q;
    end else if (ma_q > mb_q) begin
      add_sum_d  = {1'b0, ma_q} - {1'b0, mb_q};
      add_sign_d = sa_q;
    end else if (mb_q > ma_q) begin
      add_sum_d  = {1'b0, mb_q} - {1'b0, ma_q};
      add_sign_d = sb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= 32'h0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          ma_q    <= {a[30:23] != 8'd0, a[22:0]};
          mb_q    <= {b[30:23] != 8'd0, b[22:0]};
          ea_q    <= a[30:23];
          eb_q    <= b[30:23];
          sa_q    <= a[31];
          sb_q    <= b[31];
          busy_q  <= 1'b1;
          state_q <= S_ALIGN;
        end
        S_ALIGN: begin
          // A zero operand or a gap wider than the mantissa contributes nothing.
          if (zero_case) begin
            if ((ea_q == 8'd0) || ((eb_q != 8'd0) && a_lt)) ma_q <= 24'd0;
            else                                             mb_q <= 24'd0;
            state_q <= S_ADD;
          end else begin
            if (a_lt) begin
              ma_q <= ma_q >> step;
              ea_q <= ea_q + step;
            end else begin
              mb_q <= mb_q >> step;
              eb_q <= eb_q + step;
            end
            if (diff <= STEP) state_q <= S_ADD;
          end
        end
        S_ADD: begin
          sum_q   <= add_sum_d;
          sign_q  <= add_sign_d;
          exp_q   <= {1'b0, a_lt ? eb_q : ea_q};
          state_q <= S_NORM;
        end
        S_NORM: begin
          if (sum_q == 25'd0) begin
            result_q    <= 32'h0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (sum_q[24]) begin
            result_q    <= (exp_inc >= 9'd255) ? {sign_q, 8'hFF, 23'h0}
                                               : {sign_q, exp_inc[7:0], sum_q[23:1]};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (sum_q[23]) begin
            result_q    <= {sign_q, exp_q[7:0], sum_q[22:0]};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (exp_q == 9'd1) begin
            result_q    <= {sign_q, 31'h0};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            // Load on the shift that brings the leading one into bit 23.
            sum_q <= sum_q << 1;
            exp_q <= exp_dec;
            if (sum_q[22]) begin
              result_q    <= {sign_q, exp_dec[7:0], sum_q[21:0], 1'b0};
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Vector table plus reset/backpressure sequences for fp_add_sequencer.
module tb_fp_add_sequencer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b, result;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;   // 0: latency not checked
    string       name;
  } vec_t;

  vec_t vecs[13];

  fp_add_sequencer #(.SHIFT_STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept one op, wait for out_valid, compare latency and scoreboard head, then handshake.
  task automatic do_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp, input int lat);
    int cnt;
    chk({name, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    a = av; b = bv; in_valid = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no out_valid after %0d cycles expected %0d", name, cnt, lat);
      void'(sb_q.pop_front());
    end else begin
      if (lat != 0) chk({name, "_lat"}, cnt, lat);
      chk({name, "_res"}, result, sb_q.pop_front());
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_ovld_clr"}, {31'h0, out_valid}, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 3,  "one_plus_one"};
    vecs[1]  = '{32'h40400000, 32'h3F000000, 32'h40600000, 4,  "three_plus_half"};
    vecs[2]  = '{32'h3F000000, 32'h40400000, 32'h40600000, 4,  "half_plus_three"};
    vecs[3]  = '{32'h3FC00000, 32'hBFA00000, 32'h3E800000, 0,  "cancel_partial"};
    vecs[4]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 3,  "cancel_full"};
    vecs[5]  = '{32'h3F800000, 32'h30800000, 32'h3F800000, 3,  "diff30"};
    vecs[6]  = '{32'h00000000, 32'hC0000000, 32'hC0000000, 3,  "zero_plus_m2"};
    vecs[7]  = '{32'h40000000, 32'h40000000, 32'h40800000, 3,  "two_plus_two"};
    vecs[8]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3,  "overflow_inf"};
    vecs[9]  = '{32'h00800000, 32'h80C00000, 32'h80000000, 3,  "underflow_negzero"};
    vecs[10] = '{32'h80000000, 32'h80000000, 32'h00000000, 3,  "negzero_sum"};
    vecs[11] = '{32'h3F800000, 32'h33800000, 32'h3F800000, 26, "diff24"};
    vecs[12] = '{32'h3F800000, 32'h33000000, 32'h3F800000, 3,  "diff25"};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result",    result,             32'h0);
    chk("rst_busy",      {31'h0, busy},      32'h0);
    chk("rst_in_ready",  {31'h0, in_ready},  32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

    for (int i = 0; i < 13; i++)
      do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

    // Backpressure in DONE with an ignored in_valid pulse.
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_enter_done", {31'h0, out_valid}, 32'h1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin a = 32'h40400000; b = 32'h3F000000; in_valid = 1'b1; end
      else in_valid = 1'b0;
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_result",    result,             32'h40000000);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_ovld",  {31'h0, out_valid}, 32'h0);
    chk("bp_release_busy",  {31'h0, busy},      32'h0);
    chk("bp_release_ready", {31'h0, in_ready},  32'h1);
    @(posedge clk); #1;
    chk("bp_pulse_ignored", {31'h0, busy},      32'h0);

    // Reset pulse mid-ALIGN aborts the op.
    a = 32'h40400000; b = 32'h3F000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_busy_align", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
    chk("abort_result",    result,             32'h0);
    chk("abort_busy",      {31'h0, busy},      32'h0);
    chk("abort_in_ready_rst", {31'h0, in_ready}, 32'h0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_result", {31'h0, out_valid}, 32'h0);
    do_op("after_abort", 32'h40400000, 32'h3F000000, 32'h40600000, 4);

    chk("scoreboard_empty", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
